// File: rtl/micro_pkg.sv
// Shared definitions for the micro UART transmitter: state encoding and parity modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Even mode makes the total count of ones even; odd mode makes it odd.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    if (mode == PARITY_ODD) begin
      return ~^d;
    end
    return ^d;
  endfunction

endpackage

// File: rtl/micro_uart_tx_if.sv
// Byte handshake between the micro sequencer (producer) and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: producer holds tx_valid/tx_data until tx_ready is seen high at a posedge.
interface micro_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy
  );

endinterface

// File: rtl/micro_uart_tx_baud_cnt.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles while run is high.
// Latency: first tick CLKS_PER_BIT cycles after run rises; tick is combinational from the count.
// Backpressure: none; clears and holds at zero whenever run is low.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping at the bit boundary; parked at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/micro_uart_tx.sv
// UART transmitter for micro OUT bytes: 8N/E/O with 1 or 2 stop bits, LSB first.
// Latency: start bit on txd right after the accepting edge; frame takes F cycles, ready again at k+F.
// Backpressure: tx_ready high only when idle; tx_valid while busy is ignored and not latched.
module micro_uart_tx
  import micro_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  micro_uart_tx_if.slave   tx,
  output logic             txd
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("micro_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("micro_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("micro_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_idx,   w_idx_nxt;
  logic       r_par,   w_par_nxt;
  logic       r_txd,   w_txd_nxt;
  logic       w_tick;
  logic       w_accept;
  logic       w_run;

  assign tx.tx_ready = (r_state == ST_IDLE);
  assign tx.tx_busy  = (r_state != ST_IDLE);
  assign w_accept    = tx.tx_valid && (r_state == ST_IDLE);
  assign w_run       = (r_state != ST_IDLE);
  assign txd         = r_txd;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; txd resets to mark so the line never dips low on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_par   <= w_par_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Next state and next line level; every transition happens on a baud tick except the accept.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_par_nxt   = r_par;
    w_txd_nxt   = r_txd;
    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_shift_nxt = tx.tx_data;
          w_par_nxt   = parity_bit(tx.tx_data, PARITY);
          w_idx_nxt   = '0;
          w_txd_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == 3'd7) begin
            w_idx_nxt = '0;
            if (PARITY != PARITY_NONE) begin
              w_state_nxt = ST_PARITY;
              w_txd_nxt   = r_par;
            end else begin
              w_state_nxt = ST_STOP;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_txd_nxt   = 1'b1;
          w_idx_nxt   = '0;
        end
      end
      ST_STOP: begin
        // r_idx counts stop-bit periods here.
        w_txd_nxt = 1'b1;
        if (w_tick) begin
          if (r_idx == LAST_STOP) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_micro_uart_tx.sv
// Scoreboard bench for micro_uart_tx: three instances (8N1, 8E2, 8O2) at CLKS_PER_BIT=4.
// Stimulus pushes expected bytes on acceptance; per-instance line monitors decode frames and compare.
// Directed vectors cover idle, timing, back-to-back, parity, drop-while-busy and mid-frame reset.
module tb_micro_uart_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Cycle stamp: advances on each posedge, read #1 after an edge or on negedges.
  always @(posedge clk) cyc <= cyc + 1;

  micro_uart_tx_if if0 ();
  micro_uart_tx_if if1 ();
  micro_uart_tx_if if2 ();

  logic [2:0] w_txd;

  micro_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx(if0), .txd(w_txd[0]));
  micro_uart_tx #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx(if1), .txd(w_txd[1]));
  micro_uart_tx #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx(if2), .txd(w_txd[2]));

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  function automatic int par_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
  endfunction

  function automatic int stop_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int nbits(input int d);
    return 10 + ((par_of(d) != 0) ? 1 : 0) + stop_of(d) - 1;
  endfunction

  // Expected line level for bit slot s of a frame carrying byte b.
  function automatic logic fbit(input int d, input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (s == 9 && par_of(d) == 1) return ^b;
    if (s == 9 && par_of(d) == 2) return ~^b;
    return 1'b1;
  endfunction

  function automatic logic rdy(input int d);
    case (d)
      0: return if0.tx_ready;
      1: return if1.tx_ready;
      default: return if2.tx_ready;
    endcase
  endfunction

  function automatic logic bsy(input int d);
    case (d)
      0: return if0.tx_busy;
      1: return if1.tx_busy;
      default: return if2.tx_busy;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] b);
    case (d)
      0: begin if0.tx_valid = v; if0.tx_data = b; end
      1: begin if1.tx_valid = v; if1.tx_data = b; end
      default: begin if2.tx_valid = v; if2.tx_data = b; end
    endcase
  endtask

  task automatic q_push(input int d, input logic [7:0] b);
    case (d)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic q_pop(input int d, output logic [7:0] b, output bit ok);
    ok = (qsize(d) != 0);
    b = 8'h00;
    if (ok) begin
      case (d)
        0: b = q0.pop_front();
        1: b = q1.pop_front();
        default: b = q2.pop_front();
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: on a falling edge, pop the expected byte and check every cycle of the frame.
  task automatic monitor(input int d);
    logic       prev = 1'b1;
    logic [7:0] exp;
    logic [7:0] got;
    logic       lvl;
    bit         ok;
    bit         abort;
    int         bad;
    forever begin
      @(negedge clk);
      if (rst_n && prev === 1'b1 && w_txd[d] === 1'b0) begin
        q_pop(d, exp, ok);
        chk($sformatf("frame_expected_d%0d", d), 32'(ok), 32'd1);
        got = 8'h00;
        bad = 0;
        abort = 0;
        for (int s = 0; s < nbits(d) * C; s++) begin
          if (s > 0) @(negedge clk);
          if (!rst_n) begin
            abort = 1;
            break;
          end
          lvl = w_txd[d];
          if (lvl !== fbit(d, exp, s / C)) bad++;
          if ((s % C) == C / 2 && (s / C) >= 1 && (s / C) <= 8) got[(s / C) - 1] = lvl;
        end
        if (!abort) begin
          chk($sformatf("decoded_byte_d%0d", d), 32'(got), 32'(exp));
          chk($sformatf("frame_shape_bad_cycles_d%0d", d), 32'(bad), 32'd0);
        end
      end
      prev = w_txd[d];
    end
  endtask

  // Offer a byte from a negedge; returns the cycle stamp of the accepting edge (-1 on timeout).
  task automatic send(input int d, input logic [7:0] b, input bit hold, output int t_acc);
    bit r;
    int n = 0;
    @(negedge clk);
    drive(d, 1'b1, b);
    t_acc = -1;
    while (n < 400) begin
      r = rdy(d);
      @(posedge clk);
      #1;
      if (r) begin
        t_acc = cyc;
        q_push(d, b);
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!hold) drive(d, 1'b0, 8'h00);
    chk($sformatf("accept_d%0d_%02h", d, b), 32'(t_acc >= 0), 32'd1);
  endtask

  task automatic wait_ready(input int d, output int t);
    int n = 0;
    t = -1;
    while (n < 400) begin
      @(negedge clk);
      if (rdy(d)) begin
        t = cyc;
        break;
      end
      n++;
    end
    chk($sformatf("ready_timeout_d%0d", d), 32'(t >= 0), 32'd1);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    int t1, t2, tr;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    // 1: reset state and 20 idle cycles.
    #12;
    chk("rst_txd", 32'(w_txd), 32'h7);
    chk("rst_ready", 32'({rdy(2), rdy(1), rdy(0)}), 32'h7);
    chk("rst_busy", 32'({bsy(2), bsy(1), bsy(0)}), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", i), 32'({w_txd, rdy(0), rdy(1), rdy(2), bsy(0), bsy(1), bsy(2)}),
          32'b111_111_000);
    end

    // 2: 0x55 on 8N1, ready again 40 cycles after accept.
    send(0, 8'h55, 1'b0, t1);
    wait_ready(0, tr);
    chk("ready_rise_55", 32'(tr - t1), 32'd40);

    // 3: 0xA3 then 0x0F with valid held.
    send(0, 8'hA3, 1'b1, t1);
    send(0, 8'h0F, 1'b0, t2);
    chk("b2b_accept_gap", 32'(t2 - t1), 32'd41);
    wait_ready(0, tr);

    // 4: 0x80 with even parity then odd parity, two stop bits.
    send(1, 8'h80, 1'b0, t1);
    repeat (38) @(negedge clk);
    chk("even_parity_bit_80", 32'(w_txd[1]), 32'd1);
    wait_ready(1, tr);
    chk("frame_len_even_s2", 32'(tr - t1), 32'd48);
    send(2, 8'h80, 1'b0, t1);
    repeat (38) @(negedge clk);
    chk("odd_parity_bit_80", 32'(w_txd[2]), 32'd0);
    wait_ready(2, tr);
    chk("frame_len_odd_s2", 32'(tr - t1), 32'd48);

    // 5: pulse 0xFF while 0x01 is in flight; it must be dropped.
    send(0, 8'h01, 1'b0, t1);
    repeat (10) @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    chk("ready_low_while_busy", 32'(rdy(0)), 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    wait_ready(0, tr);
    chk("ready_rise_01", 32'(tr - t1), 32'd40);
    repeat (50) @(negedge clk);
    chk("dropped_ff_q_empty", 32'(qsize(0)), 32'd0);

    // 6: reset during data bit 3 of 0x00, then 0x3C intact.
    send(0, 8'h00, 1'b0, t1);
    repeat (18) @(negedge clk);
    chk("pre_reset_txd_low", 32'(w_txd[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 32'(w_txd[0]), 32'd1);
    chk("async_rst_ready", 32'(rdy(0)), 32'd1);
    chk("async_rst_busy", 32'(bsy(0)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst_ready", 32'(rdy(0)), 32'd1);
    send(0, 8'h3C, 1'b0, t1);
    wait_ready(0, tr);
    chk("ready_rise_3c", 32'(tr - t1), 32'd40);

    repeat (10) @(negedge clk);
    chk("final_q0_empty", 32'(qsize(0)), 32'd0);
    chk("final_q1_empty", 32'(qsize(1)), 32'd0);
    chk("final_q2_empty", 32'(qsize(2)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
